prog_loader: RTL and testbench

Byte-stream program loader that writes OSECPU instruction words into the instruction Memory from the write side, the counterpart of the core's fetch path, which only reads Memory. It parses a framed image (magic, word count, big-endian words, optional checksum), issues one Memory write per assembled 32-bit word, and holds the core in reset until the image is fully and correctly loaded. It sits between a byte source (UART receiver or host bridge) and Memory's `addr`/`wdata`/`we` port.

---
 rtl/loader_pkg.sv | 33 +++
 rtl/prog_loader.sv | 249 ++++++++++++++++++++++++
 tb/tb_prog_loader.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// Shared definitions for the OSECPU program loader: FSM encodings, frame magic
// and error codes.
package loader_pkg;

  typedef enum logic [3:0] {
    ST_MAGIC = 4'd0,
    ST_LEN   = 4'd1,
    ST_DATA  = 4'd2,
    ST_WRITE = 4'd3,
    ST_CSUM  = 4'd4,
    ST_DONE  = 4'd5,
    ST_ERR   = 4'd6
  } state_t;

  localparam logic [31:0] MAGIC_WORD = 32'h05E200CF;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_COUNT = 2'd1;
  localparam logic [1:0] ERR_CSUM  = 2'd2;

  // Magic bytes are matched MSB first
  function automatic logic [7:0] magic_byte(input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = MAGIC_WORD[31:24];
      2'd1:    b = MAGIC_WORD[23:16];
      2'd2:    b = MAGIC_WORD[15:8];
      default: b = MAGIC_WORD[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/prog_loader.sv
// Byte-stream program loader writing framed OSECPU images into instruction Memory.
// Optional trailing XOR checksum byte is enabled by defining LOADER_CHECKSUM_EN.
module prog_loader
  import loader_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter logic [15:0] MAX_WORDS = 16'd1024
) (
  input  logic        clk_org,
  input  logic        reset_n,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic        cpu_hold,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code,
  output logic [15:0] words_loaded
);

  state_t      state_r, state_next_s;
  logic [1:0]  magic_idx_r;
  logic        len_idx_r;
  logic [15:0] count_r;
  logic [1:0]  byte_idx_r;
  logic [31:0] word_r;
  logic [15:0] index_r;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  csum_r;
`endif

  logic        in_ready_s;
  logic        accept_s;
  logic [15:0] count_full_s;
  logic        last_word_s;
  logic        magic_hit_s;

  logic [15:0] mem_addr_r;
  logic [31:0] mem_wdata_r;
  logic        mem_we_r;
  logic        cpu_hold_r;
  logic        done_r;
  logic        error_r;
  logic [1:0]  err_code_r;
  logic [15:0] words_loaded_r;

  assign accept_s     = in_valid && in_ready_s;
  assign count_full_s = {count_r[15:8], in_data};
  assign last_word_s  = ((index_r + 16'd1) == count_r);
  assign magic_hit_s  = (in_data == magic_byte(magic_idx_r));

  // State register
  always_ff @(posedge clk_org or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_MAGIC;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode; start overrides any byte in flight
  always_comb begin
    state_next_s = state_r;
    if (start) begin
      state_next_s = ST_MAGIC;
    end else begin
      case (state_r)
        ST_MAGIC: begin
          if (accept_s && magic_hit_s && (magic_idx_r == 2'd3)) state_next_s = ST_LEN;
          else                                                   state_next_s = ST_MAGIC;
        end
        ST_LEN: begin
          if (accept_s && len_idx_r) begin
            if (count_full_s == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
              state_next_s = ST_CSUM;
`else
              state_next_s = ST_DONE;
`endif
            end else if (count_full_s > MAX_WORDS) begin
              state_next_s = ST_ERR;
            end else begin
              state_next_s = ST_DATA;
            end
          end else begin
            state_next_s = ST_LEN;
          end
        end
        ST_DATA: begin
          if (accept_s && (byte_idx_r == 2'd3)) state_next_s = ST_WRITE;
          else                                  state_next_s = ST_DATA;
        end
        ST_WRITE: begin
          if (last_word_s) begin
`ifdef LOADER_CHECKSUM_EN
            state_next_s = ST_CSUM;
`else
            state_next_s = ST_DONE;
`endif
          end else begin
            state_next_s = ST_DATA;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        ST_CSUM: begin
          if (accept_s) begin
            if (in_data == csum_r) state_next_s = ST_DONE;
            else                   state_next_s = ST_ERR;
          end else begin
            state_next_s = ST_CSUM;
          end
        end
`endif
        ST_DONE:  state_next_s = ST_DONE;
        ST_ERR:   state_next_s = ST_ERR;
        default:  state_next_s = ST_MAGIC;
      endcase
    end
  end

  // Byte acceptance decoded from state, blocked during a restart pulse
  always_comb begin
    in_ready_s = 1'b0;
    if (start) begin
      in_ready_s = 1'b0;
    end else begin
      case (state_r)
        ST_MAGIC, ST_LEN, ST_DATA, ST_CSUM: in_ready_s = 1'b1;
        default:                            in_ready_s = 1'b0;
      endcase
    end
  end

  // Datapath: frame parsing, word assembly, counters and registered outputs
  always_ff @(posedge clk_org or negedge reset_n) begin
    if (!reset_n) begin
      magic_idx_r    <= 2'd0;
      len_idx_r      <= 1'b0;
      count_r        <= 16'd0;
      byte_idx_r     <= 2'd0;
      word_r         <= 32'd0;
      index_r        <= 16'd0;
`ifdef LOADER_CHECKSUM_EN
      csum_r         <= 8'd0;
`endif
      mem_addr_r     <= 16'd0;
      mem_wdata_r    <= 32'd0;
      mem_we_r       <= 1'b0;
      cpu_hold_r     <= 1'b1;
      done_r         <= 1'b0;
      error_r        <= 1'b0;
      err_code_r     <= ERR_NONE;
      words_loaded_r <= 16'd0;
    end else if (start) begin
      magic_idx_r    <= 2'd0;
      len_idx_r      <= 1'b0;
      count_r        <= 16'd0;
      byte_idx_r     <= 2'd0;
      word_r         <= 32'd0;
      index_r        <= 16'd0;
`ifdef LOADER_CHECKSUM_EN
      csum_r         <= 8'd0;
`endif
      mem_addr_r     <= 16'd0;
      mem_wdata_r    <= 32'd0;
      mem_we_r       <= 1'b0;
      cpu_hold_r     <= 1'b1;
      done_r         <= 1'b0;
      error_r        <= 1'b0;
      err_code_r     <= ERR_NONE;
      words_loaded_r <= 16'd0;
    end else begin
      mem_we_r   <= (state_next_s == ST_WRITE);
      done_r     <= (state_next_s == ST_DONE);
      cpu_hold_r <= (state_next_s != ST_DONE);
      error_r    <= (state_next_s == ST_ERR);
      case (state_r)
        ST_MAGIC: begin
          if (accept_s) begin
            if (magic_hit_s)              magic_idx_r <= magic_idx_r + 2'd1;
            else if (in_data == 8'h05)    magic_idx_r <= 2'd1;
            else                          magic_idx_r <= 2'd0;
          end else begin
            magic_idx_r <= magic_idx_r;
          end
        end
        ST_LEN: begin
          if (accept_s && !len_idx_r) begin
            count_r[15:8] <= in_data;
            len_idx_r     <= 1'b1;
          end else if (accept_s) begin
            count_r   <= count_full_s;
            len_idx_r <= 1'b0;
            if (count_full_s > MAX_WORDS) err_code_r <= ERR_COUNT;
            else                          err_code_r <= err_code_r;
          end else begin
            len_idx_r <= len_idx_r;
          end
        end
        ST_DATA: begin
          if (accept_s) begin
            word_r     <= {word_r[23:0], in_data};
            byte_idx_r <= byte_idx_r + 2'd1;
`ifdef LOADER_CHECKSUM_EN
            csum_r     <= csum_r ^ in_data;
`endif
            // Present the write one cycle early so the strobe sees stable data
            if (byte_idx_r == 2'd3) begin
              mem_addr_r  <= BASE_ADDR + index_r;
              mem_wdata_r <= {word_r[23:0], in_data};
            end else begin
              mem_addr_r  <= mem_addr_r;
            end
          end else begin
            word_r <= word_r;
          end
        end
        ST_WRITE: begin
          index_r        <= index_r + 16'd1;
          words_loaded_r <= words_loaded_r + 16'd1;
        end
`ifdef LOADER_CHECKSUM_EN
        ST_CSUM: begin
          if (accept_s && (in_data != csum_r)) err_code_r <= ERR_CSUM;
          else                                 err_code_r <= err_code_r;
        end
`endif
        default: begin
          index_r <= index_r;
        end
      endcase
    end
  end

  assign in_ready     = in_ready_s;
  assign mem_addr     = mem_addr_r;
  assign mem_wdata    = mem_wdata_r;
  assign mem_we       = mem_we_r;
  assign cpu_hold     = cpu_hold_r;
  assign done         = done_r;
  assign error        = error_r;
  assign err_code     = err_code_r;
  assign words_loaded = words_loaded_r;

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader; follows LOADER_CHECKSUM_EN
// to decide whether frames carry the trailing checksum byte.
module tb_prog_loader;

  logic        clk_org = 1'b0;
  logic        reset_n;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [1:0]  err_code;
  logic [15:0] words_loaded;

  int checks = 0;
  int errors = 0;

  logic [15:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [7:0]  csum_acc;

  prog_loader dut (
    .clk_org(clk_org), .reset_n(reset_n), .start(start),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .cpu_hold(cpu_hold), .done(done), .error(error),
    .err_code(err_code), .words_loaded(words_loaded)
  );

  always #5 clk_org = ~clk_org;

  // Log every write strobe, one entry per high cycle
  always @(negedge clk_org) begin
    if (mem_we === 1'b1) begin
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_wdata);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called just after a falling edge; returns just after the falling edge that follows acceptance
  task automatic send_byte(input logic [7:0] b);
    int guard;
    guard = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && guard < 50) begin
      @(negedge clk_org);
      guard++;
    end
    if (guard >= 50) begin
      checks++; errors++;
      $display("FAIL send_byte_timeout: in_ready=%b required 1", in_ready);
    end
    @(negedge clk_org);
    in_valid = 1'b0;
  endtask

  task automatic send_header(input logic [15:0] count);
    send_byte(8'h05); send_byte(8'hE2); send_byte(8'h00); send_byte(8'hCF);
    send_byte(count[15:8]); send_byte(count[7:0]);
    csum_acc = 8'h00;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) begin
      send_byte(w[i*8 +: 8]);
      csum_acc = csum_acc ^ w[i*8 +: 8];
    end
  endtask

  task automatic send_csum();
`ifdef LOADER_CHECKSUM_EN
    send_byte(csum_acc);
`endif
  endtask

  task automatic wait_end(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (done === 1'b1 || error === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk_org);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk_org);
    start = 1'b0;
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  task automatic test_reset();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (mem_addr !== 16'h0000) begin errors++; $display("FAIL reset_mem_addr: got %h want 0000", mem_addr); end
    checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
    checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL reset_cpu_hold: got %b want 1", cpu_hold); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b want 0", error); end
    checks++; if (err_code !== 2'd0) begin errors++; $display("FAIL reset_err_code: got %0d want 0", err_code); end
    checks++; if (words_loaded !== 16'd0) begin errors++; $display("FAIL reset_words_loaded: got %0d want 0", words_loaded); end
  endtask

  task automatic test_nominal();
    bit ok;
    send_header(16'd2);
    send_word(32'hD3040000);
    send_word(32'hF0000000);
    checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL nominal_hold_during_load: got %b want 1", cpu_hold); end
    send_csum();
    wait_end(ok);
    checks++; if (!ok) begin errors++; $display("FAIL nominal_end_timeout: done=%b want 1", done); end
    checks++; if (wr_addr_q.size() !== 2) begin errors++; $display("FAIL nominal_we_count: got %0d want 2", wr_addr_q.size()); end
    if (wr_addr_q.size() == 2) begin
      checks++; if (wr_addr_q[0] !== 16'd0 || wr_data_q[0] !== 32'hD3040000) begin errors++; $display("FAIL nominal_word0: got %h@%h want d3040000@0000", wr_data_q[0], wr_addr_q[0]); end
      checks++; if (wr_addr_q[1] !== 16'd1 || wr_data_q[1] !== 32'hF0000000) begin errors++; $display("FAIL nominal_word1: got %h@%h want f0000000@0001", wr_data_q[1], wr_addr_q[1]); end
    end
    checks++; if (done !== 1'b1 || cpu_hold !== 1'b0) begin errors++; $display("FAIL nominal_done: done=%b hold=%b want 1/0", done, cpu_hold); end
    checks++; if (words_loaded !== 16'd2) begin errors++; $display("FAIL nominal_words_loaded: got %0d want 2", words_loaded); end
    checks++; if (in_ready !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL nominal_idle: in_ready=%b error=%b want 0/0", in_ready, error); end
  endtask

  task automatic test_resync();
    bit ok;
    do_start();
    checks++; if (done !== 1'b0 || cpu_hold !== 1'b1 || words_loaded !== 16'd0) begin errors++; $display("FAIL start_clears: done=%b hold=%b wl=%0d want 0/1/0", done, cpu_hold, words_loaded); end
    send_byte(8'h05);
    send_header(16'd1);
    send_word(32'h12345678);
    send_csum();
    wait_end(ok);
    checks++; if (!ok || done !== 1'b1) begin errors++; $display("FAIL resync_done: done=%b error=%b want 1/0", done, error); end
    checks++; if (wr_addr_q.size() !== 1) begin errors++; $display("FAIL resync_we_count: got %0d want 1", wr_addr_q.size()); end
    else begin
      checks++; if (wr_addr_q[0] !== 16'd0 || wr_data_q[0] !== 32'h12345678) begin errors++; $display("FAIL resync_word: got %h@%h want 12345678@0000", wr_data_q[0], wr_addr_q[0]); end
    end
  endtask

  task automatic test_len_error();
    bit ok;
    do_start();
    send_header(16'h0401);
    wait_end(ok);
    checks++; if (!ok || error !== 1'b1) begin errors++; $display("FAIL len_error_flag: error=%b want 1", error); end
    checks++; if (err_code !== 2'd1) begin errors++; $display("FAIL len_err_code: got %0d want 1", err_code); end
    checks++; if (wr_addr_q.size() !== 0) begin errors++; $display("FAIL len_no_write: got %0d writes want 0", wr_addr_q.size()); end
    checks++; if (in_ready !== 1'b0 || cpu_hold !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL len_after: in_ready=%b hold=%b done=%b want 0/1/0", in_ready, cpu_hold, done); end
  endtask

  task automatic test_bad_csum();
`ifdef LOADER_CHECKSUM_EN
    bit ok;
    do_start();
    send_header(16'd1);
    send_word(32'hA5A5A5A5);
    send_byte(csum_acc ^ 8'h01);
    wait_end(ok);
    checks++; if (wr_addr_q.size() !== 1) begin errors++; $display("FAIL csum_word_written: got %0d writes want 1", wr_addr_q.size()); end
    checks++; if (!ok || error !== 1'b1 || err_code !== 2'd2) begin errors++; $display("FAIL csum_error: error=%b code=%0d want 1/2", error, err_code); end
    checks++; if (cpu_hold !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL csum_hold: hold=%b done=%b want 1/0", cpu_hold, done); end
`endif
  endtask

  task automatic test_restart();
    bit ok;
    do_start();
    send_header(16'd2);
    send_word(32'h11223344);
    send_byte(8'hAA);
    send_byte(8'hBB);
    checks++; if (words_loaded !== 16'd1) begin errors++; $display("FAIL restart_progress: wl=%0d want 1", words_loaded); end
    in_data  = 8'hCC;
    in_valid = 1'b1;
    start    = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL restart_in_ready: got %b want 0", in_ready); end
    @(negedge clk_org);
    start    = 1'b0;
    in_valid = 1'b0;
    wr_addr_q.delete();
    wr_data_q.delete();
    checks++; if (words_loaded !== 16'd0 || done !== 1'b0 || error !== 1'b0 || cpu_hold !== 1'b1) begin errors++; $display("FAIL restart_clear: wl=%0d done=%b err=%b hold=%b want 0/0/0/1", words_loaded, done, error, cpu_hold); end
    send_header(16'd1);
    send_word(32'hCAFEF00D);
    send_csum();
    wait_end(ok);
    checks++; if (!ok || done !== 1'b1) begin errors++; $display("FAIL restart_done: done=%b error=%b want 1/0", done, error); end
    checks++; if (wr_addr_q.size() !== 1) begin errors++; $display("FAIL restart_we_count: got %0d want 1", wr_addr_q.size()); end
    else begin
      checks++; if (wr_addr_q[0] !== 16'd0 || wr_data_q[0] !== 32'hCAFEF00D) begin errors++; $display("FAIL restart_word: got %h@%h want cafef00d@0000", wr_data_q[0], wr_addr_q[0]); end
    end
    checks++; if (words_loaded !== 16'd1) begin errors++; $display("FAIL restart_words_loaded: got %0d want 1", words_loaded); end
  endtask

  task automatic test_count_zero();
    bit ok;
    do_start();
    send_header(16'd0);
    send_csum();
    wait_end(ok);
    checks++; if (!ok || done !== 1'b1 || cpu_hold !== 1'b0) begin errors++; $display("FAIL zero_done: done=%b hold=%b want 1/0", done, cpu_hold); end
    checks++; if (wr_addr_q.size() !== 0 || words_loaded !== 16'd0) begin errors++; $display("FAIL zero_no_write: writes=%0d wl=%0d want 0/0", wr_addr_q.size(), words_loaded); end
  endtask

  task automatic test_async_reset();
    do_start();
    send_header(16'd2);
    send_word(32'h0BADCAFE);
    send_byte(8'h01);
    send_byte(8'h02);
    checks++; if (words_loaded !== 16'd1 || mem_wdata !== 32'h0BADCAFE) begin errors++; $display("FAIL areset_pre: wl=%0d wdata=%h want 1/0badcafe", words_loaded, mem_wdata); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1 || mem_addr !== 16'd0 || mem_wdata !== 32'd0 || mem_we !== 1'b0) begin errors++; $display("FAIL areset_mem: rdy=%b addr=%h wdata=%h we=%b want 1/0/0/0", in_ready, mem_addr, mem_wdata, mem_we); end
    checks++; if (cpu_hold !== 1'b1 || done !== 1'b0 || error !== 1'b0 || err_code !== 2'd0 || words_loaded !== 16'd0) begin errors++; $display("FAIL areset_status: hold=%b done=%b err=%b code=%0d wl=%0d want 1/0/0/0/0", cpu_hold, done, error, err_code, words_loaded); end
    @(negedge clk_org);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n  = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    csum_acc = 8'h00;
    repeat (2) @(negedge clk_org);
    reset_n = 1'b1;
    @(negedge clk_org);
    test_reset();
    test_nominal();
    test_resync();
    test_len_error();
    test_bad_csum();
    test_restart();
    test_count_zero();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
